// File: rtl/spy_if.sv
// Strobe-level link between the xbus spy bridge (master) and the spy register bank (slave).
interface spy_if;
    logic [3:0]  spyreg;
    logic        spywr;
    logic        spyrd;
    logic [15:0] spy_wdata;
    logic [15:0] spy_rdata;

    modport master (output spyreg, spywr, spyrd, spy_wdata, input spy_rdata);
    modport slave  (input spyreg, spywr, spyrd, spy_wdata, output spy_rdata);
endinterface

// File: rtl/spy_regs.sv
// Spy register bank: debug IR, control, step sequencer and CPU reset pulse.
// Optional PC history FIFO (read via register 8) enabled by defining SPY_PCHIST_EN.
module spy_regs #(
    parameter int unsigned RESET_WIDTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    spy_if.slave        bus,
    input  logic [13:0] cpu_pc,
    input  logic        cpu_halted,
    output logic [47:0] ir_out,
    output logic        ir_load,
    output logic        cpu_run,
    output logic        cpu_step,
    output logic        cpu_reset
);
    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT_LOW, S_WAIT_HALT} state_t;

    state_t      state_q, state_d;
    logic [47:0] ir_q, ir_d;
    logic        ir_load_q, ir_load_d;
    logic        run_q, run_d;
    logic        step_q, step_d;
    logic        rst_q, rst_d;
    logic [7:0]  rst_cnt_q, rst_cnt_d;
    logic        dbg_en_q, dbg_en_d;
    logic [15:0] count_q, count_d;
    logic [15:0] scratch_q, scratch_d;
    logic [15:0] rdata_q, rdata_d;
    logic [3:0]  to_cnt_q, to_cnt_d;
    logic        step_busy, step_done;
    logic [15:0] hist_rdata;

    assign step_busy = (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        ir_load_d = 1'b0;
        run_d     = run_q;
        rst_d     = rst_q;
        rst_cnt_d = rst_cnt_q;
        dbg_en_d  = dbg_en_q;
        count_d   = count_q;
        scratch_d = scratch_q;
        rdata_d   = rdata_q;
        to_cnt_d  = to_cnt_q;
        step_done = 1'b0;

        if (rst_cnt_q != 8'd0) rst_cnt_d = rst_cnt_q - 8'd1;
        else                   rst_d     = 1'b0;

        case (state_q)
            S_PULSE: begin
                state_d  = S_WAIT_LOW;
                to_cnt_d = 4'd14;
            end
            S_WAIT_LOW: begin
                // a CPU that never leaves halt still counts as having stepped
                if (!cpu_halted)             state_d   = S_WAIT_HALT;
                else if (to_cnt_q == 4'd0)   step_done = 1'b1;
                else                         to_cnt_d  = to_cnt_q - 4'd1;
            end
            S_WAIT_HALT: if (cpu_halted) step_done = 1'b1;
            default: ;
        endcase

        if (step_done) begin
            count_d = count_q - 16'd1;
            state_d = (count_q != 16'd1) ? S_PULSE : S_IDLE;
        end

        if (bus.spywr) begin
            case (bus.spyreg)
                4'd0: ir_d[15:0]  = bus.spy_wdata;
                4'd1: ir_d[31:16] = bus.spy_wdata;
                4'd2: begin
                    ir_d[47:32] = bus.spy_wdata;
                    ir_load_d   = 1'b1;
                end
                4'd3: begin
                    run_d    = bus.spy_wdata[0];
                    dbg_en_d = bus.spy_wdata[3];
                    if (bus.spy_wdata[2]) begin
                        rst_d     = 1'b1;
                        rst_cnt_d = 8'(RESET_WIDTH - 1);
                        run_d     = 1'b0;
                        state_d   = S_IDLE;
                    end else if (bus.spy_wdata[0] && step_busy) begin
                        state_d = S_IDLE;
                    end else if (bus.spy_wdata[1] && !step_busy && count_q != 16'd0
                                 && !run_q && !bus.spy_wdata[0]) begin
                        state_d = S_PULSE;
                    end
                end
                4'd4: if (!step_busy) count_d = bus.spy_wdata;
                4'd6: scratch_d = bus.spy_wdata;
                default: ;
            endcase
        end

        // reads see register contents from before any same-cycle write
        if (bus.spyrd) begin
            case (bus.spyreg)
                4'd0:    rdata_d = ir_q[15:0];
                4'd1:    rdata_d = ir_q[31:16];
                4'd2:    rdata_d = ir_q[47:32];
                4'd3:    rdata_d = {12'b0, dbg_en_q, 2'b00, run_q};
                4'd4:    rdata_d = count_q;
                4'd5:    rdata_d = {13'b0, cpu_halted, step_busy, run_q};
                4'd6:    rdata_d = scratch_q;
                4'd7:    rdata_d = {2'b00, cpu_pc};
                4'd8:    rdata_d = hist_rdata;
                default: rdata_d = 16'h0000;
            endcase
        end

        step_d = (state_d == S_PULSE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            ir_load_q <= 1'b0;
            run_q     <= 1'b0;
            step_q    <= 1'b0;
            rst_q     <= 1'b0;
            rst_cnt_q <= '0;
            dbg_en_q  <= 1'b0;
            count_q   <= '0;
            scratch_q <= '0;
            rdata_q   <= '0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            ir_load_q <= ir_load_d;
            run_q     <= run_d;
            step_q    <= step_d;
            rst_q     <= rst_d;
            rst_cnt_q <= rst_cnt_d;
            dbg_en_q  <= dbg_en_d;
            count_q   <= count_d;
            scratch_q <= scratch_d;
            rdata_q   <= rdata_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

`ifdef SPY_PCHIST_EN
    logic [13:0] hist_mem_q [4];
    logic [13:0] hist_mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]  hist_cnt_q, hist_cnt_d;

    assign hist_rdata = (hist_cnt_q != 3'd0) ? {2'b10, hist_mem_q[rd_ptr_q]} : 16'h0000;

    always_comb begin
        hist_mem_d = hist_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        hist_cnt_d = hist_cnt_q;
        if (bus.spyrd && bus.spyreg == 4'd8 && hist_cnt_q != 3'd0) begin
            rd_ptr_d   = rd_ptr_q + 2'd1;
            hist_cnt_d = hist_cnt_q - 3'd1;
        end
        // full FIFO drops its oldest entry to make room
        if (step_q) begin
            hist_mem_d[wr_ptr_q] = cpu_pc;
            wr_ptr_d = wr_ptr_q + 2'd1;
            if (hist_cnt_d == 3'd4) rd_ptr_d   = rd_ptr_d + 2'd1;
            else                    hist_cnt_d = hist_cnt_d + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_mem_q <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            hist_cnt_q <= '0;
        end else begin
            hist_mem_q <= hist_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            hist_cnt_q <= hist_cnt_d;
        end
    end
`else
    assign hist_rdata = 16'h0000;
`endif

    assign bus.spy_rdata = rdata_q;
    assign ir_out        = ir_q;
    assign ir_load       = ir_load_q;
    assign cpu_run       = run_q;
    assign cpu_step      = step_q;
    assign cpu_reset     = rst_q;
endmodule

// File: tb/tb_spy_regs.sv
// Directed bench for spy_regs with a simple halting-CPU model.
module tb_spy_regs;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] pc_base = 14'h1234;
    logic [13:0] pc_off = '0;
    logic [13:0] cpu_pc;
    logic        cpu_halted = 1'b1;
    logic        model_en = 1'b1;
    logic [47:0] ir_out;
    logic        ir_load, cpu_run, cpu_step, cpu_reset;
    int          checks = 0;
    int          failures = 0;
    int          step_pulses = 0;
    int          load_pulses = 0;
    int          rst_cycles = 0;
    int          snap, snap2;
    logic [15:0] rd;

    spy_if bus ();

    spy_regs #(.RESET_WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .cpu_pc     (cpu_pc),
        .cpu_halted (cpu_halted),
        .ir_out     (ir_out),
        .ir_load    (ir_load),
        .cpu_run    (cpu_run),
        .cpu_step   (cpu_step),
        .cpu_reset  (cpu_reset)
    );

    assign cpu_pc = pc_base + pc_off;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cpu_step)  step_pulses++;
        if (ir_load)   load_pulses++;
        if (cpu_reset) rst_cycles++;
    end

    // CPU leaves halt 2 cycles after a step and re-halts 5 cycles later at the next PC
    always begin
        @(negedge clk);
        if (cpu_step && model_en) begin
            repeat (2) @(negedge clk);
            cpu_halted = 1'b0;
            repeat (5) @(negedge clk);
            cpu_halted = 1'b1;
            pc_off = pc_off + 14'd1;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] r, input logic [15:0] d);
        bus.spyreg = r; bus.spy_wdata = d; bus.spywr = 1'b1;
        @(negedge clk);
        bus.spywr = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] r, output logic [15:0] d);
        bus.spyreg = r; bus.spyrd = 1'b1;
        @(negedge clk);
        bus.spyrd = 1'b0;
        d = bus.spy_rdata;
    endtask

    initial begin
        bus.spyreg = '0; bus.spywr = 1'b0; bus.spyrd = 1'b0; bus.spy_wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_rdata", bus.spy_rdata, 16'h0);
        check("rst_outs", {ir_out, ir_load, cpu_run, cpu_step, cpu_reset}, 52'h0);
        for (int i = 0; i < 8; i++) begin
            bus_read(4'(i), rd);
            if (i == 5)      check("rst_reg5", rd, 16'h0004);
            else if (i == 7) check("rst_reg7", rd, 16'h1234);
            else             check($sformatf("rst_reg%0d", i), rd, 16'h0000);
        end

        // IR load
        snap = load_pulses;
        bus_write(4'd0, 16'h1111);
        bus_write(4'd1, 16'h2222);
        check("ir_load_early", ir_load, 1'b0);
        bus_write(4'd2, 16'h3333);
        check("ir_load_cycle", ir_load, 1'b1);
        repeat (3) @(negedge clk);
        check("ir_load_once", load_pulses - snap, 1);
        check("ir_out", ir_out, 48'h333322221111);
        bus_read(4'd1, rd);
        check("ir_mid_read", rd, 16'h2222);

        // scratch, control dbg_en, unmapped, same-cycle read/write
        bus_write(4'd6, 16'hABCD);
        bus.spyreg = 4'd6; bus.spy_wdata = 16'h1234; bus.spywr = 1'b1; bus.spyrd = 1'b1;
        @(negedge clk);
        bus.spywr = 1'b0; bus.spyrd = 1'b0;
        check("rw_same_cycle", bus.spy_rdata, 16'hABCD);
        bus_read(4'd6, rd);
        check("scratch_new", rd, 16'h1234);
        bus_write(4'd3, 16'h0008);
        bus_read(4'd3, rd);
        check("ctl_dbg_en", rd, 16'h0008);
        bus_write(4'd9, 16'hFFFF);
        bus_read(4'd9, rd);
        check("reg9_zero", rd, 16'h0000);

        // three-step sequence
        snap = step_pulses;
        bus_write(4'd4, 16'd3);
        bus_write(4'd3, 16'h0002);
        check("step_first_cycle", cpu_step, 1'b1);
        repeat (60) @(negedge clk);
        check("step_count3", step_pulses - snap, 3);
        bus_read(4'd4, rd);
        check("step_remaining", rd, 16'h0000);
        bus_read(4'd5, rd);
        check("step_status", rd, 16'h0004);

        // starts that must be ignored
        snap = step_pulses;
        bus_write(4'd3, 16'h0002);
        check("start_cnt0_pulse", cpu_step, 1'b0);
        bus_write(4'd4, 16'd2);
        bus_write(4'd3, 16'h0001);
        bus_write(4'd3, 16'h0003);
        repeat (20) @(negedge clk);
        check("start_ignored", step_pulses - snap, 0);
        bus_write(4'd3, 16'h0000);

        // count write while busy is ignored
        snap = step_pulses;
        bus_write(4'd4, 16'd3);
        bus_write(4'd3, 16'h0002);
        repeat (3) @(negedge clk);
        bus_write(4'd4, 16'd5);
        repeat (80) @(negedge clk);
        check("busy_wr_steps", step_pulses - snap, 3);
        bus_read(4'd4, rd);
        check("busy_wr_count", rd, 16'h0000);

        // cpu_run write aborts a running sequence, count kept
        snap = step_pulses;
        bus_write(4'd4, 16'd3);
        bus_write(4'd3, 16'h0002);
        repeat (3) @(negedge clk);
        bus_write(4'd3, 16'h0001);
        repeat (20) @(negedge clk);
        check("run_abort_steps", step_pulses - snap, 1);
        bus_read(4'd5, rd);
        check("run_abort_status", rd, 16'h0005);
        bus_read(4'd4, rd);
        check("run_abort_count", rd, 16'd3);

        // reset request clears cpu_run
        snap = rst_cycles;
        bus_write(4'd3, 16'h0004);
        check("rstreq_run", cpu_run, 1'b0);
        repeat (10) @(negedge clk);
        check("rstreq_width", rst_cycles - snap, 4);

        // reset request aborts a step sequence
        bus_write(4'd4, 16'd4);
        bus_write(4'd3, 16'h0002);
        repeat (12) @(negedge clk);
        snap = rst_cycles;
        bus_write(4'd3, 16'h0004);
        snap2 = step_pulses;
        repeat (40) @(negedge clk);
        check("rst_abort_width", rst_cycles - snap, 4);
        check("rst_abort_steps", step_pulses - snap2, 0);
        bus_read(4'd5, rd);
        check("rst_abort_status", rd, 16'h0004);

        // re-request during the pulse restarts the width
        snap = rst_cycles;
        bus_write(4'd3, 16'h0004);
        bus_write(4'd3, 16'h0004);
        repeat (10) @(negedge clk);
        check("rst_rerequest", rst_cycles - snap, 5);

        // CPU never leaves halt: step completes on timeout
        model_en = 1'b0;
        snap = step_pulses;
        bus_write(4'd4, 16'd1);
        bus_write(4'd3, 16'h0002);
        repeat (9) @(negedge clk);
        bus_read(4'd5, rd);
        check("timeout_busy", rd, 16'h0006);
        repeat (10) @(negedge clk);
        bus_read(4'd5, rd);
        check("timeout_done", rd, 16'h0004);
        check("timeout_steps", step_pulses - snap, 1);
        model_en = 1'b1;

`ifdef SPY_PCHIST_EN
        pc_base = 14'd10 - pc_off;
        bus_write(4'd4, 16'd5);
        bus_write(4'd3, 16'h0002);
        repeat (80) @(negedge clk);
        bus_read(4'd8, rd); check("hist0", rd, 16'h800B);
        bus_read(4'd8, rd); check("hist1", rd, 16'h800C);
        bus_read(4'd8, rd); check("hist2", rd, 16'h800D);
        bus_read(4'd8, rd); check("hist3", rd, 16'h800E);
        bus_read(4'd8, rd); check("hist_empty", rd, 16'h0000);
`else
        bus_read(4'd8, rd);
        check("reg8_zero", rd, 16'h0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
